// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Single-port data-memory responder for the execute-stage
//                dmem bundle. Word-addressed scratchpad, one outstanding
//                request, WAIT_STATES wait cycles, one mem_ready pulse per
//                accepted request carrying read data or an out-of-range flag.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous reset, active low
//                mem_valid  - request present (held until mem_ready)
//                mem_instr  - fetch tag, no functional effect
//                mem_addr   - byte address, bits [1:0] ignored
//                mem_wdata  - store data
//                mem_wstrb  - byte-lane write enables, 0 = read
//                mem_ready  - one-cycle response pulse
//                mem_rdata  - read data, zero outside the pulse
//                mem_error  - out-of-range flag, zero outside the pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_error
);

    localparam int          c_depth     = 1 << DEPTH_LOG2;
    // Byte span of the array, 33 bits wide so DEPTH_LOG2 = 30 does not wrap.
    localparam logic [32:0] c_span      = 33'd4 << DEPTH_LOG2;
    localparam logic [3:0]  c_wait_load = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_armed;
    logic [31:0] r_mem [c_depth];

    logic                  w_accept;
    logic                  w_enter_resp;
    logic [31:0]           w_req_addr;
    logic [31:0]           w_req_wdata;
    logic [3:0]            w_req_wstrb;
    logic [31:0]           w_offset;
    logic                  w_in_range;
    logic                  w_is_write;
    logic [DEPTH_LOG2-1:0] w_index;
    logic                  w_commit;
    logic                  w_unused_ok;

    assign w_unused_ok = mem_instr;

    // r_armed is cleared by reset and set on the first clock after release.
    // Gating acceptance with it keeps a request held across reset from being
    // accepted (and, with zero wait states, written) while reset is active.
    assign w_accept     = r_armed && (r_state == c_st_idle) && mem_valid;
    assign w_enter_resp = (w_accept && (WAIT_STATES == 0)) ||
                          ((r_state == c_st_wait) && (r_cnt == 4'd0));

    // With zero wait states the request is served at its acceptance edge,
    // before it reaches the latches, so the live inputs are used in IDLE.
    assign w_req_addr  = (r_state == c_st_idle) ? mem_addr  : r_addr;
    assign w_req_wdata = (r_state == c_st_idle) ? mem_wdata : r_wdata;
    assign w_req_wstrb = (r_state == c_st_idle) ? mem_wstrb : r_wstrb;

    // Unsigned wrap-around subtraction: addresses below BASE_ADDR become huge
    // offsets and fail the range check.
    assign w_offset   = w_req_addr - BASE_ADDR;
    assign w_in_range = ({1'b0, w_offset} < c_span);
    assign w_index    = w_offset[DEPTH_LOG2+1:2];
    assign w_is_write = |w_req_wstrb;
    assign w_commit   = w_enter_resp && w_in_range && w_is_write;

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_req_wstrb[i]) begin
                    r_mem[w_index][8*i +: 8] <= w_req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_st_idle;
            r_cnt     <= 4'd0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_armed   <= 1'b0;
            mem_ready <= 1'b0;
            mem_rdata <= 32'd0;
            mem_error <= 1'b0;
        end else begin
            r_armed <= 1'b1;

            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_addr  <= mem_addr;
                        r_wdata <= mem_wdata;
                        r_wstrb <= mem_wstrb;
                        if (WAIT_STATES == 0) begin
                            r_state <= c_st_resp;
                        end else begin
                            r_state <= c_st_wait;
                            r_cnt   <= c_wait_load;
                        end
                    end
                end
                c_st_wait: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= c_st_resp;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_st_resp: begin
                    // mem_valid here still belongs to the request just served.
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase

            // Outputs are registered at the edge entering RESP and forced to
            // zero at every other edge, so they are non-zero only in RESP.
            mem_ready <= w_enter_resp;
            mem_error <= w_enter_resp && !w_in_range;
            mem_rdata <= (w_enter_resp && w_in_range && !w_is_write) ? r_mem[w_index] : 32'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. Three instances:
//                u_w1 (WAIT_STATES=1, base 0), u_w0 (WAIT_STATES=0, base 0),
//                u_w3 (WAIT_STATES=3, base 32'h8000_0000). Table-driven
//                request vectors plus hand-written reset, back-to-back and
//                abandon sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic [2:0]  valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  rdy;
    logic [2:0]  err;
    logic [31:0] rd [3];

    int n_checks;
    int n_fail;
    int c_waits [3] = '{1, 0, 3};

    dmem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(1), .BASE_ADDR(32'h0)) u_w1 (
        .clk(clk), .rst(rst), .mem_valid(valid[0]), .mem_instr(instr),
        .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb),
        .mem_ready(rdy[0]), .mem_rdata(rd[0]), .mem_error(err[0]));

    dmem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_w0 (
        .clk(clk), .rst(rst), .mem_valid(valid[1]), .mem_instr(instr),
        .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb),
        .mem_ready(rdy[1]), .mem_rdata(rd[1]), .mem_error(err[1]));

    dmem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(3), .BASE_ADDR(32'h8000_0000)) u_w3 (
        .clk(clk), .rst(rst), .mem_valid(valid[2]), .mem_instr(instr),
        .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb),
        .mem_ready(rdy[2]), .mem_rdata(rd[2]), .mem_error(err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one request to instance idx and wait (bounded) for its pulse.
    // hold=0 drops mem_valid right after the acceptance edge (abandon case).
    task automatic run_req(input int idx, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input bit hold,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input string name);
        int   cyc;
        bit   got;
        logic [31:0] cap_d;
        logic        cap_e;
        @(negedge clk);
        valid[idx] = 1'b1;
        addr  = a;
        wdata = d;
        wstrb = s;
        cyc   = 0;
        got   = 1'b0;
        cap_d = 32'd0;
        cap_e = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (rdy[idx]) begin
                got   = 1'b1;
                cap_d = rd[idx];
                cap_e = err[idx];
            end
            if (!hold && cyc == 1) valid[idx] = 1'b0;
        end
        valid[idx] = 1'b0;
        wstrb = 4'd0;
        check({name, "_latency"}, 32'(cyc), 32'(1 + c_waits[idx]));
        check({name, "_rdata"}, cap_d, exp_rdata);
        check({name, "_error"}, {31'd0, cap_e}, {31'd0, exp_err});
        @(negedge clk);
        check({name, "_single_pulse"}, {29'd0, rdy[idx]}, 32'd0);
    endtask

    initial begin
        int pulses;
        int p1;
        int p2;
        logic [31:0] d1;
        logic [31:0] d2;

        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b0;
        valid = 3'b000;
        instr = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        wstrb = 4'd0;

        vecs[0]  = '{0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
        vecs[1]  = '{0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{0, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0, 1'b0};
        vecs[3]  = '{0, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0};
        vecs[4]  = '{0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
        vecs[5]  = '{0, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0};
        vecs[6]  = '{0, 32'h0000_1000, 32'h1234_5678, 4'hF, 32'h0, 1'b1};
        vecs[7]  = '{0, 32'h0000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
        vecs[8]  = '{0, 32'h0000_0FFC, 32'h0A0B_0C0D, 4'hF, 32'h0, 1'b0};
        vecs[9]  = '{0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h0A0B_0C0D, 1'b0};
        vecs[10] = '{0, 32'h0000_0013, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[11] = '{0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0, 1'b1};
        vecs[12] = '{1, 32'h0000_0010, 32'h0102_0304, 4'hF, 32'h0, 1'b0};
        vecs[13] = '{1, 32'h0000_0010, 32'hFF00_00EE, 4'b1000, 32'h0, 1'b0};
        vecs[14] = '{1, 32'h0000_0010, 32'h0,         4'h0, 32'hFF02_0304, 1'b0};
        vecs[15] = '{2, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0, 1'b1};
        vecs[16] = '{2, 32'h8000_0040, 32'h55AA_55AA, 4'hF, 32'h0, 1'b0};
        vecs[17] = '{2, 32'h8000_0040, 32'h0,         4'h0, 32'h55AA_55AA, 1'b0};
        vecs[18] = '{2, 32'h8000_1000, 32'h0,         4'h0, 32'h0, 1'b1};
        vecs[19] = '{2, 32'h0000_0040, 32'h0,         4'h0, 32'h0, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_ready_error", {26'd0, rdy, err}, 32'd0);
        check("reset_rdata", rd[0] | rd[1] | rd[2], 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            run_req(vecs[i].idx, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 1'b1,
                    vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Reset held with requests pending on every instance
        @(negedge clk);
        rst   = 1'b0;
        valid = 3'b111;
        addr  = 32'h10;
        wdata = 32'h0;
        wstrb = 4'hF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("inreset_ready_error_%0d", c), {26'd0, rdy, err}, 32'd0);
            check($sformatf("inreset_rdata_%0d", c), rd[0] | rd[1] | rd[2], 32'd0);
        end
        rst   = 1'b1;
        valid = 3'b000;
        wstrb = 4'h0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rdy != 3'b000) pulses++;
        end
        check("post_reset_no_pulse", 32'(pulses), 32'd0);
        run_req(0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, "after_reset_w1");
        run_req(1, 32'h10, 32'h0, 4'h0, 1'b1, 32'hFF02_0304, 1'b0, "after_reset_w0");

        // Held valid, back-to-back: write then read, changing only after ready
        @(negedge clk);
        valid[0] = 1'b1;
        addr  = 32'h40;
        wdata = 32'h1111_1111;
        wstrb = 4'hF;
        pulses = 0;
        p1 = 0;
        p2 = 0;
        d1 = 32'hFFFF_FFFF;
        d2 = 32'h0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (rdy[0]) begin
                pulses++;
                if (pulses == 1) begin
                    p1 = c;
                    d1 = rd[0];
                    wdata = 32'h0;
                    wstrb = 4'h0;
                end else if (pulses == 2) begin
                    p2 = c;
                    d2 = rd[0];
                    valid[0] = 1'b0;
                end
            end
        end
        valid[0] = 1'b0;
        check("b2b_pulse_count", 32'(pulses), 32'd2);
        check("b2b_first_latency", 32'(p1), 32'd2);
        check("b2b_spacing", 32'(p2 - p1), 32'd3);
        check("b2b_write_rdata", d1, 32'h0);
        check("b2b_read_rdata", d2, 32'h1111_1111);

        // Reset during WAIT drops the write and the response
        run_req(0, 32'h30, 32'h0BAD_F00D, 4'hF, 1'b1, 32'h0, 1'b0, "pre_write_30");
        @(negedge clk);
        valid[0] = 1'b1;
        addr  = 32'h30;
        wdata = 32'hFFFF_FFFF;
        wstrb = 4'hF;
        @(negedge clk);
        rst = 1'b0;
        valid[0] = 1'b0;
        wstrb = 4'h0;
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (rdy[0]) pulses++;
        end
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rdy[0]) pulses++;
        end
        check("midreset_no_pulse", 32'(pulses), 32'd0);
        run_req(0, 32'h30, 32'h0, 4'h0, 1'b1, 32'h0BAD_F00D, 1'b0, "midreset_readback");

        // Abandoned request still completes and commits
        run_req(2, 32'h8000_0050, 32'h600D_CAFE, 4'hF, 1'b0, 32'h0, 1'b0, "abandon_write");
        run_req(2, 32'h8000_0050, 32'h0, 4'h0, 1'b1, 32'h600D_CAFE, 1'b0, "abandon_readback");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
